// File: rtl/mem_ctrl.sv
// Byte-serial memory controller for instruction fetch and LSB load/store traffic.
// One transaction in flight; LSB requests win over fetch requests when both are pending.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        in_fetcher_flag,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_flag,
    output logic [31:0] out_fetcher_inst,

    input  logic        in_lsb_flag,
    input  logic        in_lsb_wr,
    input  logic [1:0]  in_lsb_size,
    input  logic [31:0] in_lsb_addr,
    input  logic [31:0] in_lsb_data,
    output logic        out_lsb_flag,
    output logic [31:0] out_lsb_data,

    input  logic        in_rob_xbp,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    logic [1:0]  state_q, state_d;

    logic        fetch_pend_q, fetch_pend_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;

    logic        lsb_pend_q, lsb_pend_d;
    logic        lsb_wr_q, lsb_wr_d;
    logic [1:0]  lsb_size_q, lsb_size_d;
    logic [31:0] lsb_addr_q, lsb_addr_d;
    logic [31:0] lsb_data_q, lsb_data_d;

    logic        is_fetch_q, is_fetch_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] prev_addr_q;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic        fetch_done_q, fetch_done_d;
    logic [31:0] inst_q, inst_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    // A pulse in the current cycle takes precedence over an older latched request.
    logic        lsb_req;
    logic        lsb_wr_eff;
    logic [1:0]  lsb_size_eff;
    logic [31:0] lsb_addr_eff;
    logic [31:0] lsb_data_eff;
    logic        fetch_req;
    logic [31:0] fetch_addr_eff;
    logic [2:0]  lsb_len;

    logic        io_stall;
    logic [2:0]  cnt_m1;
    logic [31:0] rd_merge;
    logic [31:0] wr_shift;

    always_comb begin
        lsb_req        = in_lsb_flag | lsb_pend_q;
        lsb_wr_eff     = in_lsb_flag ? in_lsb_wr   : lsb_wr_q;
        lsb_size_eff   = in_lsb_flag ? in_lsb_size : lsb_size_q;
        lsb_addr_eff   = in_lsb_flag ? in_lsb_addr : lsb_addr_q;
        lsb_data_eff   = in_lsb_flag ? in_lsb_data : lsb_data_q;
        fetch_req      = in_fetcher_flag | (fetch_pend_q & ~in_rob_xbp);
        fetch_addr_eff = in_fetcher_flag ? in_fetcher_addr : fetch_addr_q;
        unique case (lsb_size_eff)
            2'b00:   lsb_len = 3'd1;
            2'b01:   lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase
    end

    assign io_stall = (addr_q >= IO_BASE) && io_buffer_full;
    assign cnt_m1   = cnt_q - 3'd1;
    assign rd_merge = rbuf_q | ({24'b0, mem_din} << {cnt_m1[1:0], 3'b000});
    assign wr_shift = wdata_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d      = state_q;
        fetch_pend_d = fetch_pend_q;
        fetch_addr_d = fetch_addr_q;
        lsb_pend_d   = lsb_pend_q;
        lsb_wr_d     = lsb_wr_q;
        lsb_size_d   = lsb_size_q;
        lsb_addr_d   = lsb_addr_q;
        lsb_data_d   = lsb_data_q;
        is_fetch_d   = is_fetch_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        fetch_done_d = 1'b0;
        inst_d       = inst_q;
        lsb_done_d   = 1'b0;
        lsb_rdata_d  = lsb_rdata_q;

        // Flush clears the pending fetch first so a same-cycle fetch pulse survives.
        if (in_rob_xbp) begin
            fetch_pend_d = 1'b0;
        end
        if (in_fetcher_flag) begin
            fetch_pend_d = 1'b1;
            fetch_addr_d = in_fetcher_addr;
        end
        if (in_lsb_flag) begin
            lsb_pend_d = 1'b1;
            lsb_wr_d   = in_lsb_wr;
            lsb_size_d = in_lsb_size;
            lsb_addr_d = in_lsb_addr;
            lsb_data_d = in_lsb_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (lsb_req) begin
                    lsb_pend_d = 1'b0;
                    is_fetch_d = 1'b0;
                    addr_d     = lsb_addr_eff;
                    len_d      = lsb_len;
                    cnt_d      = 3'd0;
                    wdata_d    = lsb_data_eff;
                    rbuf_d     = 32'h0;
                    state_d    = lsb_wr_eff ? ST_WRITE : ST_READ;
                end else if (fetch_req) begin
                    fetch_pend_d = 1'b0;
                    is_fetch_d   = 1'b1;
                    addr_d       = fetch_addr_eff;
                    len_d        = 3'd4;
                    cnt_d        = 3'd0;
                    rbuf_d       = 32'h0;
                    state_d      = ST_READ;
                end
            end

            ST_READ: begin
                if (is_fetch_q && in_rob_xbp) begin
                    state_d = ST_IDLE;
                end else begin
                    // mem_din lags mem_a by one cycle, so byte k-1 arrives at count k.
                    if (cnt_q != 3'd0) begin
                        rbuf_d = rd_merge;
                    end
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                        if (is_fetch_q) begin
                            fetch_done_d = 1'b1;
                            inst_d       = rd_merge;
                        end else begin
                            lsb_done_d  = 1'b1;
                            lsb_rdata_d = rd_merge;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        if ((cnt_q + 3'd1) < len_q) begin
                            addr_d = addr_q + 32'd1;
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (!io_stall) begin
                    if (cnt_q == len_q - 3'd1) begin
                        state_d     = ST_IDLE;
                        lsb_done_d  = 1'b1;
                        lsb_rdata_d = 32'h0;
                    end else begin
                        cnt_d  = cnt_q + 3'd1;
                        addr_d = addr_q + 32'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pend_q <= 1'b0;
            fetch_addr_q <= 32'h0;
            lsb_pend_q   <= 1'b0;
            lsb_wr_q     <= 1'b0;
            lsb_size_q   <= 2'b00;
            lsb_addr_q   <= 32'h0;
            lsb_data_q   <= 32'h0;
            is_fetch_q   <= 1'b0;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            addr_q       <= 32'h0;
            prev_addr_q  <= 32'h0;
            wdata_q      <= 32'h0;
            rbuf_q       <= 32'h0;
            fetch_done_q <= 1'b0;
            inst_q       <= 32'h0;
            lsb_done_q   <= 1'b0;
            lsb_rdata_q  <= 32'h0;
        end else if (rdy) begin
            state_q      <= state_d;
            fetch_pend_q <= fetch_pend_d;
            fetch_addr_q <= fetch_addr_d;
            lsb_pend_q   <= lsb_pend_d;
            lsb_wr_q     <= lsb_wr_d;
            lsb_size_q   <= lsb_size_d;
            lsb_addr_q   <= lsb_addr_d;
            lsb_data_q   <= lsb_data_d;
            is_fetch_q   <= is_fetch_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            prev_addr_q  <= addr_q;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            fetch_done_q <= fetch_done_d;
            inst_q       <= inst_d;
            lsb_done_q   <= lsb_done_d;
            lsb_rdata_q  <= lsb_rdata_d;
        end
    end

    // While frozen, re-present the address whose byte is still awaited so a free-running
    // RAM keeps that byte on mem_din until the controller resumes.
    assign mem_a            = rdy ? addr_q : prev_addr_q;
    assign mem_wr           = rdy && (state_q == ST_WRITE) && !io_stall;
    assign mem_dout         = (state_q == ST_WRITE) ? wr_shift[7:0] : 8'h00;
    assign out_fetcher_flag = fetch_done_q;
    assign out_fetcher_inst = inst_q;
    assign out_lsb_flag     = lsb_done_q;
    assign out_lsb_data     = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic scored
// against a byte-array memory model and per-port expected-result queues.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        in_fetcher_flag;
    logic [31:0] in_fetcher_addr;
    logic        out_fetcher_flag;
    logic [31:0] out_fetcher_inst;
    logic        in_lsb_flag, in_lsb_wr;
    logic [1:0]  in_lsb_size;
    logic [31:0] in_lsb_addr, in_lsb_data;
    logic        out_lsb_flag;
    logic [31:0] out_lsb_data;
    logic        in_rob_xbp;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_fetcher_flag  (in_fetcher_flag),
        .in_fetcher_addr  (in_fetcher_addr),
        .out_fetcher_flag (out_fetcher_flag),
        .out_fetcher_inst (out_fetcher_inst),
        .in_lsb_flag      (in_lsb_flag),
        .in_lsb_wr        (in_lsb_wr),
        .in_lsb_size      (in_lsb_size),
        .in_lsb_addr      (in_lsb_addr),
        .in_lsb_data      (in_lsb_data),
        .out_lsb_flag     (out_lsb_flag),
        .out_lsb_data     (out_lsb_data),
        .in_rob_xbp       (in_rob_xbp),
        .mem_din          (mem_din),
        .mem_dout         (mem_dout),
        .mem_a            (mem_a),
        .mem_wr           (mem_wr),
        .io_buffer_full   (io_buffer_full)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned e0       = 0;
    int unsigned fetch_seen = 0, lsb_seen = 0;
    int unsigned last_fetch_cyc = 0, last_lsb_cyc = 0;

    logic [7:0]  ram       [0:262143];
    logic [7:0]  model_mem [0:262143];
    logic [31:0] exp_fetch [$];
    logic [31:0] exp_lsb   [$];
    logic [39:0] io_log    [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running synchronous RAM; writes at or above the I/O base go to a log instead.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr) begin
            if (mem_a >= 32'h0003_0000) io_log.push_back({mem_a, mem_dout});
            else ram[mem_a[17:0]] <= mem_dout;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!rdy) check("frozen_mem_wr", {31'b0, mem_wr}, 32'h0);
            if (rdy && out_fetcher_flag) begin
                fetch_seen++;
                last_fetch_cyc = cyc;
                check("fetch_expected", {31'b0, exp_fetch.size() != 0}, 32'h1);
                if (exp_fetch.size() != 0) check("fetch_inst", out_fetcher_inst, exp_fetch.pop_front());
            end
            if (rdy && out_lsb_flag) begin
                lsb_seen++;
                last_lsb_cyc = cyc;
                check("lsb_expected", {31'b0, exp_lsb.size() != 0}, 32'h1);
                if (exp_lsb.size() != 0) check("lsb_data", out_lsb_data, exp_lsb.pop_front());
            end
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] v = 32'h0;
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = a + i;
            v[8*i +: 8] = model_mem[p[17:0]];
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prep_fetch(input logic [31:0] a, input bit expect_done);
        in_fetcher_flag = 1'b1;
        in_fetcher_addr = a;
        if (expect_done) exp_fetch.push_back(model_read(a, 4));
    endtask

    task automatic prep_lsb(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d);
        logic [31:0] p;
        in_lsb_flag = 1'b1;
        in_lsb_wr   = wr;
        in_lsb_size = sz;
        in_lsb_addr = a;
        in_lsb_data = d;
        if (wr) begin
            for (int i = 0; i < nbytes(sz); i++) begin
                p = a + i;
                model_mem[p[17:0]] = d[8*i +: 8];
            end
            exp_lsb.push_back(32'h0);
        end else begin
            exp_lsb.push_back(model_read(a, nbytes(sz)));
        end
    endtask

    task automatic fire();
        rdy = 1'b1;
        step();
        e0 = cyc;
        in_fetcher_flag = 1'b0;
        in_lsb_flag     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_rdy);
        int n = 0;
        while ((exp_fetch.size() != 0 || exp_lsb.size() != 0) && n < budget) begin
            step();
            n++;
            if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
        end
        rdy = 1'b1;
        check("drain_timeout", exp_fetch.size() + exp_lsb.size(), 32'h0);
        exp_fetch.delete();
        exp_lsb.delete();
    endtask

    initial begin
        int unsigned f0, l0, io0;
        logic [31:0] a;
        logic [1:0]  sz;

        rst = 1'b1; rdy = 1'b1;
        in_fetcher_flag = 0; in_fetcher_addr = 0;
        in_lsb_flag = 0; in_lsb_wr = 0; in_lsb_size = 0; in_lsb_addr = 0; in_lsb_data = 0;
        in_rob_xbp = 0; io_buffer_full = 0;
        for (int i = 0; i < 262144; i++) begin
            ram[i] = (i < 32'h2000) ? 8'($urandom) : 8'h00;
            model_mem[i] = ram[i];
        end
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        for (int i = 0; i < 4; i++) model_mem[i] = ram[i];
        repeat (3) step();
        rst = 1'b0;

        check("rst_fetch_flag", {31'b0, out_fetcher_flag}, 32'h0);
        check("rst_lsb_flag",   {31'b0, out_lsb_flag}, 32'h0);
        check("rst_mem_wr",     {31'b0, mem_wr}, 32'h0);
        check("rst_mem_a",      mem_a, 32'h0);
        check("rst_lsb_data",   out_lsb_data, 32'h0);
        check("rst_inst",       out_fetcher_inst, 32'h0);

        // Fetch at 0 returns the addi encoding with fixed latency.
        prep_fetch(32'h0, 1'b1);
        fire();
        wait_done(50, 1'b0);
        check("fetch_latency", last_fetch_cyc - e0, 32'd5);

        // Word store then sub-word loads of the same bytes.
        prep_lsb(1'b1, 2'b10, 32'h100, 32'hDEAD_BEEF); fire(); wait_done(50, 1'b0);
        prep_lsb(1'b0, 2'b00, 32'h101, 32'h0);         fire(); wait_done(50, 1'b0);
        prep_lsb(1'b0, 2'b01, 32'h102, 32'h0);         fire(); wait_done(50, 1'b0);
        check("model_byte_be", model_read(32'h101, 1), 32'h0000_00BE);

        // Simultaneous requests: LSB served first, each done exactly once.
        f0 = fetch_seen; l0 = lsb_seen;
        prep_fetch(32'h0, 1'b1);
        prep_lsb(1'b0, 2'b00, 32'h200, 32'h0);
        fire();
        wait_done(60, 1'b0);
        check("both_fetch_once", fetch_seen - f0, 32'd1);
        check("both_lsb_once",   lsb_seen - l0, 32'd1);
        check("lsb_before_fetch", {31'b0, last_lsb_cyc < last_fetch_cyc}, 32'h1);

        // Flush after two fetch bytes are captured; no done may follow.
        f0 = fetch_seen;
        prep_fetch(32'h4, 1'b0);
        fire();
        repeat (3) step();
        in_rob_xbp = 1'b1;
        step();
        in_rob_xbp = 1'b0;
        repeat (10) step();
        check("flush_no_fetch", fetch_seen - f0, 32'd0);
        prep_fetch(32'h8, 1'b1); fire(); wait_done(50, 1'b0);

        // I/O byte store stalled by a full output buffer.
        io0 = io_log.size();
        io_buffer_full = 1'b1;
        prep_lsb(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
        fire();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("io_stall_wr", {31'b0, mem_wr}, 32'h0);
            step();
        end
        io_buffer_full = 1'b0;
        wait_done(50, 1'b0);
        check("io_write_count", io_log.size() - io0, 32'd1);
        if (io_log.size() > io0) begin
            check("io_addr", io_log[io0][39:8], 32'h0003_0000);
            check("io_data", {24'b0, io_log[io0][7:0]}, 32'h41);
        end

        // Freeze for four cycles in the middle of a word load.
        prep_lsb(1'b0, 2'b10, 32'h1000, 32'h0);
        fire();
        repeat (2) step();
        rdy = 1'b0;
        repeat (4) step();
        rdy = 1'b1;
        wait_done(50, 1'b0);
        check("rdy_latency", last_lsb_cyc - e0, 32'd9);

        // Randomized traffic with random freezes while transactions are in flight.
        for (int it = 0; it < 60; it++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'h1000 + $urandom_range(0, 32'h3FF);
            case ($urandom_range(0, 3))
                0: prep_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'b1);
                1: prep_lsb(1'b1, sz, a, $urandom);
                2: prep_lsb(1'b0, sz, a, 32'h0);
                default: begin
                    prep_fetch({20'h0, 10'($urandom_range(0, 1023)), 2'b00}, 1'b1);
                    prep_lsb(1'b0, sz, a, 32'h0);
                end
            endcase
            fire();
            wait_done(200, 1'b1);
        end

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
